// File: rtl/gcd_sched_pkg.sv
// Shared state encoding, default sizes and id-width helper for the GCD
// engine scheduler (gcd_scheduler and gcd_rr_arbiter).
package gcd_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // A two-requester build still needs a 1-bit id.
  function automatic int calc_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr,
// wrapping modulo NUM_REQ.
module gcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  int                 scan_idx;
  logic [NUM_REQ-1:0] hit;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    hit         = '0;
    // Walk from the farthest offset back to rr_ptr so the nearest set bit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      hit      = req >> scan_idx;
      if (hit[0]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one GCD engine among NUM_REQ requesters.
// Optional GCD_ZERO_BYPASS_EN answers zero-operand requests without the engine.
module gcd_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Handshake: a requester raises req[i] with stable operands and holds it
  // until ack[i] pulses; operands are sampled once at grant, so later operand
  // changes or a post-grant drop of req have no effect on that transaction.
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         resp_gcd,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_a,
  output logic [WIDTH-1:0]         eng_b,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_gcd,
  output state_e                   dbg_state
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, grant_id_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q, result_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q, eng_start_q;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               zero_op;
  logic [ID_W-1:0]    resp_id;

  gcd_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign sel_a = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b = req_b[grant_idx*WIDTH +: WIDTH];

`ifdef GCD_ZERO_BYPASS_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The bypass path reaches RESP straight from IDLE, before grant_id_q is loaded.
  assign resp_id = (state_q == ST_IDLE) ? grant_idx : grant_id_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_valid) state_d = zero_op ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (eng_done) state_d = ST_DRAIN;
      ST_DRAIN: if (!eng_done) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != ST_IDLE);
      eng_start_q <= (state_d == ST_ISSUE);
      ack_q       <= (state_d == ST_RESP) ? (NUM_REQ'(1) << resp_id) : '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_id_q <= grant_idx;
            op_a_q     <= sel_a;
            op_b_q     <= sel_b;
            if (zero_op) result_q <= sel_a | sel_b;
          end
        end
        // Only the first done cycle is captured; DRAIN absorbs the rest.
        ST_BUSY: if (eng_done) result_q <= eng_gcd;
        ST_RESP: rr_ptr_q <= (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign ack       = ack_q;
  assign resp_gcd  = result_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_a     = op_a_q;
  assign eng_b     = op_b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: table vectors, hand sequences for arbitration,
// reset and engine corner cases, and randomized round-robin traffic.
module tb_gcd_scheduler;
  import gcd_sched_pkg::*;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int SB_W = N + W;
`ifdef GCD_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   resp_gcd;
  logic [1:0]     grant_id;
  logic           busy, eng_start;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done;
  logic [W-1:0]   eng_gcd;
  state_e         dbg_state;

  gcd_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .resp_gcd(resp_gcd), .grant_id(grant_id), .busy(busy),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_gcd(eng_gcd), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and check helpers ----------------
  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no ack within cycle budget", name);
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] rand_op();
    int unsigned g;
    if ($urandom_range(0, 7) == 0) return '0;
    g = $urandom_range(1, 60);
    return W'(g * $urandom_range(1, 1000));
  endfunction

  // ---------------- engine model: latency, 2-cycle done ----------------
  int unsigned lat_min = 1, lat_max = 5;
  int eng_wait, eng_hold;
  int spur_cnt = 0, spur_seen = 0;
  logic [W-1:0] ea, eb, sa, sb;
  bit st;

  initial begin
    eng_done = 1'b0;
    eng_gcd  = '0;
    eng_wait = 0;
    eng_hold = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        eng_done = 1'b0;
        eng_wait = 0;
        eng_hold = 0;
      end else begin
        st = eng_start;
        sa = eng_a;
        sb = eng_b;
        #1;
        if (eng_hold > 0) begin
          eng_hold--;
          if (eng_hold == 0) begin
            eng_done = 1'b0;
            eng_gcd  = W'($urandom);
          end
        end else if (spur_cnt != spur_seen) begin
          spur_seen++;
          eng_done = 1'b1;
          eng_gcd  = W'($urandom);
          eng_hold = 2;
        end
        if (st) begin
          eng_wait = $urandom_range(lat_min, lat_max);
          ea = sa;
          eb = sb;
        end else if (eng_wait > 0) begin
          eng_wait--;
          if (eng_wait == 0) begin
            eng_done = 1'b1;
            eng_gcd  = ref_gcd(ea, eb);
            eng_hold = 2;
          end
        end
      end
    end
  end

  // ---------------- monitor logs ----------------
  typedef struct { int cyc; logic [N-1:0] ack; logic [W-1:0] gcd; } ack_ev_t;
  typedef struct { int cyc; logic [W-1:0] a; logic [W-1:0] b; } start_ev_t;
  ack_ev_t   ack_log[$];
  start_ev_t start_log[$];
  int        done_log[$];
  logic      done_prev = 1'b0;

  always @(negedge clk) begin
    if (ack != 0) ack_log.push_back('{cyc, ack, resp_gcd});
    if (eng_start) start_log.push_back('{cyc, eng_a, eng_b});
    if (eng_done && !done_prev) done_log.push_back(cyc);
    done_prev = eng_done;
  end

  // ---------------- scoreboard state for random traffic ----------------
  logic [SB_W-1:0] exp_q[$];
  logic [W-1:0]    job_a[N][8];
  logic [W-1:0]    job_b[N][8];
  int              job_k[N];

  // ---------------- driver tasks ----------------
  task automatic run_one(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
    int am, sm, dm, c0, ack_c;
    bit seen, byp;
    @(negedge clk);
    am = ack_log.size();
    sm = start_log.size();
    dm = done_log.size();
    c0 = cyc;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req[r] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (ack != 0) seen = 1'b1;
    end
    if (!seen) fail({tag, "_timeout"});
    ack_c = cyc;
    check({tag, "_ack"}, 32'(ack), 32'(1) << r);
    check({tag, "_gcd"}, 32'(resp_gcd), 32'(exp));
    check({tag, "_gid"}, 32'(grant_id), 32'(r));
    req[r] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_len"}, 32'(ack), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    byp = BYP && (a == '0 || b == '0);
    check({tag, "_starts"}, 32'(start_log.size() - sm), byp ? 32'd0 : 32'd1);
    check({tag, "_acks"}, 32'(ack_log.size() - am), 32'd1);
    if (byp) begin
      check({tag, "_lat"}, 32'(ack_c), 32'(c0 + 1));
    end else if (start_log.size() > sm && done_log.size() > dm) begin
      check({tag, "_start_cyc"}, 32'(start_log[sm].cyc), 32'(c0 + 1));
      check({tag, "_eng_a"}, 32'(start_log[sm].a), 32'(a));
      check({tag, "_eng_b"}, 32'(start_log[sm].b), 32'(b));
      check({tag, "_lat"}, 32'(ack_c), 32'(done_log[dm] + 3));
    end
    model_ptr = (r + 1) % N;
  endtask

  task automatic wait_ack(input string tag, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (ack != 0) ok = 1'b1;
    end
    if (!ok) fail(tag);
  endtask

  task automatic serve_rnd(input int n_acks, input int rounds);
    int got;
    logic [SB_W-1:0] exp;
    got = 0;
    for (int t = 0; t < 60 * n_acks && got < n_acks; t++) begin
      @(negedge clk);
      if (ack != 0) begin
        got++;
        exp = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
        check("rnd_ack", 32'({ack, resp_gcd}), 32'(exp));
        for (int i = 0; i < N; i++) begin
          if (ack[i]) begin
            job_k[i]++;
            if (job_k[i] < rounds) begin
              req_a[i*W +: W] = job_a[i][job_k[i]];
              req_b[i*W +: W] = job_b[i][job_k[i]];
            end else begin
              req[i] = 1'b0;
            end
          end
        end
      end
    end
    if (got < n_acks) fail("rnd_serve");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start"}, 32'(eng_start), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
    check({tag, "_resp"}, 32'(resp_gcd), 32'd0);
    check({tag, "_eng_a"}, 32'(eng_a), 32'd0);
    check({tag, "_eng_b"}, 32'(eng_b), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  typedef struct { int r; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;
  vec_t vecs[8];

  initial begin
    bit ok;
    int got, am, total, rounds, last;
    logic [N-1:0] mask;
    logic [N-1:0] order_ack[4];
    logic [W-1:0] order_gcd[4];
    int exp4[4];

    vecs[0] = '{0, 16'd48,    16'd18,    16'd6};
    vecs[1] = '{1, 16'd1,     16'd65535, 16'd1};
    vecs[2] = '{2, 16'd0,     16'd21,    16'd21};
    vecs[3] = '{3, 16'd21,    16'd0,     16'd21};
    vecs[4] = '{0, 16'd0,     16'd0,     16'd0};
    vecs[5] = '{1, 16'd100,   16'd75,    16'd25};
    vecs[6] = '{2, 16'd65535, 16'd65535, 16'd65535};
    vecs[7] = '{3, 16'd7,     16'd13,    16'd1};
    exp4 = '{4, 7, 9, 1};

    rst_n = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");

    // All four requesters at once: served 0,1,2,3 from rr_ptr=0.
    @(negedge clk);
    req_a = {16'd17, 16'd9,  16'd35, 16'd12};
    req_b = {16'd5,  16'd27, 16'd14, 16'd8};
    req   = 4'b1111;
    got = 0;
    for (int t = 0; t < 400 && got < 4; t++) begin
      @(negedge clk);
      if (ack != 0) begin
        order_ack[got] = ack;
        order_gcd[got] = resp_gcd;
        got++;
        req = req & ~ack;
      end
    end
    if (got < 4) fail("rr4_timeout");
    for (int k = 0; k < got; k++) begin
      check("rr4_ack", 32'(order_ack[k]), 32'(1) << k);
      check("rr4_gcd", 32'(order_gcd[k]), 32'(exp4[k]));
    end
    req = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_one(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // req[2] held; req[1] raised after ack[2] must be served before 2 again.
    @(negedge clk);
    req_a[2*W +: W] = 16'd30;
    req_b[2*W +: W] = 16'd12;
    req[2] = 1'b1;
    wait_ack("rr_first_to", ok);
    check("rr_first", 32'({ack, resp_gcd}), 32'({4'b0100, 16'd6}));
    req_a[1*W +: W] = 16'd20;
    req_b[1*W +: W] = 16'd15;
    req[1] = 1'b1;
    wait_ack("rr_second_to", ok);
    check("rr_second", 32'({ack, resp_gcd}), 32'({4'b0010, 16'd5}));
    req[1] = 1'b0;
    wait_ack("rr_third_to", ok);
    check("rr_third", 32'({ack, resp_gcd}), 32'({4'b0100, 16'd6}));
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    model_ptr = 3;

    // Spurious done while idle must be ignored.
    am = ack_log.size();
    spur_cnt++;
    repeat (5) @(negedge clk);
    check("spur_no_ack", 32'(ack_log.size() - am), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_state", 32'(dbg_state), 32'(ST_IDLE));
    run_one(1, 16'd48, 16'd18, 16'd6, "spur_after");

    // Reset while the engine is still working.
    lat_min = 8;
    lat_max = 8;
    @(negedge clk);
    req_a[3*W +: W] = 16'd48;
    req_b[3*W +: W] = 16'd18;
    req[3] = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_pre_state", 32'(dbg_state), 32'(ST_BUSY));
    am = ack_log.size();
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_ack", 32'(ack_log.size() - am), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);
    lat_min = 1;
    lat_max = 5;
    run_one(0, 16'd100, 16'd75, 16'd25, "rst_after");

    // Randomized traffic: a fixed subset holds req, renewing operands on each ack.
    for (int ph = 0; ph < 5; ph++) begin
      mask   = N'($urandom_range(1, (1 << N) - 1));
      rounds = $urandom_range(2, 4);
      total  = 0;
      last   = model_ptr;
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 8; k++) begin
          job_a[i][k] = rand_op();
          job_b[i][k] = rand_op();
        end
      for (int k = 0; k < rounds; k++)
        for (int off = 0; off < N; off++) begin
          int i;
          i = (model_ptr + off) % N;
          if (mask[i]) begin
            exp_q.push_back({N'(1) << i, ref_gcd(job_a[i][k], job_b[i][k])});
            total++;
            last = i;
          end
        end
      model_ptr = (last + 1) % N;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        job_k[i] = 0;
        if (mask[i]) begin
          req_a[i*W +: W] = job_a[i][0];
          req_b[i*W +: W] = job_b[i][0];
          req[i] = 1'b1;
        end
      end
      serve_rnd(total, rounds);
      check("rnd_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      req = '0;
      repeat (3) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
